pc_counter: RTL and testbench

- Program counter for the single-cycle datapath.
- Holds the current 8-bit instruction-memory address on `direccion` and advances it once per clock.
- Supports synchronous reset, stall, absolute jump and PC-relative branch.
- Output drives the instruction memory address bus directly.

---
 rtl/pc_counter.sv | 83 ++++++++
 tb/tb_pc_counter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pc_counter.sv
// Program counter: registered instruction-memory address with reset, stall, jump and relative branch.
// Optional `wrap` overflow flag output is enabled by defining PC_WRAP_FLAG_EN.
module pc_counter #(
    parameter int                 ADDR_W     = 8,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
    parameter int unsigned        STEP       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_off,
`ifdef PC_WRAP_FLAG_EN
    output logic              wrap,
`endif
    output logic [ADDR_W-1:0] direccion
);

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    // Initialiser gives a defined address before the first clock edge.
    logic [ADDR_W-1:0] r_pc = RESET_ADDR;
    logic [ADDR_W-1:0] w_next;
    logic [ADDR_W-1:0] w_inc_sum;
    logic [ADDR_W-1:0] w_br_sum;

`ifdef PC_WRAP_FLAG_EN
    logic [ADDR_W:0]   w_inc;
    logic [ADDR_W:0]   w_br;
    logic              w_carry;
    logic              r_wrap = 1'b0;

    assign w_inc     = {1'b0, r_pc} + {1'b0, STEP_V};
    assign w_br      = {1'b0, r_pc} + {1'b0, branch_off};
    assign w_inc_sum = w_inc[ADDR_W-1:0];
    assign w_br_sum  = w_br[ADDR_W-1:0];

    // Carry out of whichever addition actually drives the next PC; jump never flags.
    always_comb begin
        w_carry = 1'b0;
        if (!jump) begin
            if (branch)
                w_carry = w_br[ADDR_W];
            else if (en)
                w_carry = w_inc[ADDR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_carry;
    end

    assign wrap = r_wrap;
`else
    assign w_inc_sum = r_pc + STEP_V;
    assign w_br_sum  = r_pc + branch_off;
`endif

    always_comb begin
        w_next = r_pc;
        if (jump)
            w_next = jump_addr;
        else if (branch)
            w_next = w_br_sum;
        else if (en)
            w_next = w_inc_sum;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= RESET_ADDR;
        else
            r_pc <= w_next;
    end

    assign direccion = r_pc;

endmodule

// File: tb/tb_pc_counter.sv
// Directed self-checking bench for pc_counter; checks wrap too when PC_WRAP_FLAG_EN is defined.
`timescale 1ns/1ps
module tb_pc_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       jump;
    logic [7:0] jump_addr;
    logic       branch;
    logic [7:0] branch_off;
    logic [7:0] direccion;
`ifdef PC_WRAP_FLAG_EN
    logic       wrap;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pc_counter dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .branch     (branch),
        .branch_off (branch_off),
`ifdef PC_WRAP_FLAG_EN
        .wrap       (wrap),
`endif
        .direccion  (direccion)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wrap(input string tag, input logic exp);
`ifdef PC_WRAP_FLAG_EN
        chk(tag, {7'b0, wrap}, {7'b0, exp});
`else
        if (exp === 1'bx) $display("unused %s", tag);
`endif
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; jump = 1'b0; jump_addr = 8'h00;
        branch = 1'b0; branch_off = 8'h00;

        #1;
        chk("powerup", direccion, 8'h00);
        step(); chk("reset1", direccion, 8'h00);
        step(); chk("reset2", direccion, 8'h00);
        chk_wrap("wrap_reset", 1'b0);

        reset = 1'b0; en = 1'b1;
        step(); chk("inc1", direccion, 8'h01);
        step(); chk("inc2", direccion, 8'h02);
        step(); chk("inc3", direccion, 8'h03);
        step(); chk("inc4", direccion, 8'h04);
        step(); chk("inc5", direccion, 8'h05);

        en = 1'b0;
        step(); chk("stall1", direccion, 8'h05);
        step(); chk("stall2", direccion, 8'h05);
        step(); chk("stall3", direccion, 8'h05);
        en = 1'b1;
        step(); chk("resume", direccion, 8'h06);

        en = 1'b0; jump = 1'b1; jump_addr = 8'h40;
        step(); chk("jump40", direccion, 8'h40);
        jump = 1'b0; branch = 1'b1; branch_off = 8'hFE;
        step(); chk("branch_neg2", direccion, 8'h3E);
        chk_wrap("wrap_branch_carry", 1'b1);
        jump = 1'b1; jump_addr = 8'h10;
        step(); chk("jump_over_branch", direccion, 8'h10);
        chk_wrap("wrap_jump", 1'b0);

        branch = 1'b0; jump_addr = 8'hFE;
        step(); chk("jumpFE", direccion, 8'hFE);
        jump = 1'b0; en = 1'b1;
        step(); chk("wrapFF", direccion, 8'hFF);
        chk_wrap("wrap_at_FF", 1'b0);
        step(); chk("wrap00", direccion, 8'h00);
        chk_wrap("wrap_at_00", 1'b1);
        step(); chk("wrap01", direccion, 8'h01);
        chk_wrap("wrap_at_01", 1'b0);

        en = 1'b0; jump = 1'b1; jump_addr = 8'h02;
        step(); chk("jump02", direccion, 8'h02);
        jump = 1'b0; branch = 1'b1; branch_off = 8'hFC;
        step(); chk("branch_wrap_FE", direccion, 8'hFE);
        chk_wrap("wrap_branch_nocarry", 1'b0);

        branch = 1'b0; en = 1'b1; jump = 1'b1; jump_addr = 8'h33;
        step(); chk("jump_with_en", direccion, 8'h33);
        jump_addr = 8'h77; branch = 1'b1; branch_off = 8'h05; reset = 1'b1;
        step(); chk("reset_priority", direccion, 8'h00);
        chk_wrap("wrap_reset_prio", 1'b0);

        reset = 1'b0; branch = 1'b0; en = 1'b0; jump_addr = 8'h33;
        step(); chk("jump33", direccion, 8'h33);
        jump = 1'b0;
        reset = 1'b1;
        #2;
        chk("reset_no_edge", direccion, 8'h33);
        reset = 1'b0;
        step(); chk("after_glitch", direccion, 8'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
